reorder_buffer: RTL

//  In-order reorder buffer directly downstream of the instruction queue.
//  - Allocates one entry per non-bubble instruction. op == 5'b11111 is a bubble.
//  - Captures execution results from the common data bus (CDB).
//  - Retires at most one entry per cycle, strictly in program order.
//  - Drives rob_full back to the instruction queue to stall issue.

---
 rtl/reorder_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order reorder buffer with CDB writeback; optional flush port under ROB_FLUSH_EN
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ROB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [4:0]       op_in,
    input  logic [4:0]       rd_in,
    input  logic [31:0]      imm_in,
    output logic             rob_full,
    output logic [IDX_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             commit_valid,
    output logic [IDX_W-1:0] commit_tag,
    output logic [4:0]       commit_op,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [31:0]      commit_imm
);
    localparam logic [4:0]       OP_BUBBLE  = 5'b11111;
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   ONE_COUNT  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    logic [4:0]       op_q    [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [IDX_W:0]   count_q;
    logic             flush_c;
    logic             alloc_en;
    logic             wb_en;
    logic             commit_en;

`ifdef ROB_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign rob_full  = (count_q == FULL_COUNT);
    assign alloc_tag = tail_q;
    // All three decisions use pre-edge state, so a slot freed by this
    // cycle's commit cannot be re-allocated in the same cycle.
    assign alloc_en  = (op_in != OP_BUBBLE) && !rob_full;
    assign wb_en     = cdb_valid && busy_q[cdb_tag] && !ready_q[cdb_tag];
    assign commit_en = busy_q[head_q] && ready_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_op    <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_imm   <= '0;
        end else if (flush_c) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            commit_valid <= 1'b0;
        end else begin
            // alloc, writeback and commit never touch the same entry:
            // tail is free, the CDB target is busy-not-ready, head is ready.
            if (alloc_en) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= tail_q + ONE_IDX;
            end
            if (wb_en) begin
                ready_q[cdb_tag] <= 1'b1;
            end
            if (commit_en) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + ONE_IDX;
                commit_valid    <= 1'b1;
                commit_tag      <= head_q;
                commit_op       <= op_q[head_q];
                commit_rd       <= rd_q[head_q];
                commit_value    <= value_q[head_q];
                commit_imm      <= imm_q[head_q];
            end else begin
                commit_valid <= 1'b0;
            end
            case ({alloc_en, commit_en})
                2'b10:   count_q <= count_q + ONE_COUNT;
                2'b01:   count_q <= count_q - ONE_COUNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: it is only read once busy/ready say it is valid.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            op_q[tail_q]  <= op_in;
            rd_q[tail_q]  <= rd_in;
            imm_q[tail_q] <= imm_in;
        end
        if (wb_en) begin
            value_q[cdb_tag] <= cdb_value;
        end
    end

endmodule
